// File: rtl/store_narrow_unit_pkg.sv
// Shared types for the narrowing store path: size codes, FSM state, range helper.
// fits_signed() is only referenced when STORE_RANGE_CHECK_EN is defined.
package store_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_WRITE = 2'b10
  } state_e;

  // True when the stored bits sign-extend back to the full register value.
  function automatic logic fits_signed(
    input logic [31:0] v,
    input logic [1:0]  sz
  );
    logic ok;
    ok = 1'b1;
    case (sz)
      SZ_BYTE: ok = (&v[31:7])  | ~(|v[31:7]);
      SZ_HALF: ok = (&v[31:15]) | ~(|v[31:15]);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/store_merge.sv
// Lane merge for sub-word stores: replaces the addressed byte/half lane of a
// little-endian word with the low bits of the register value.
module store_merge
  import store_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    case (size_i)
      SZ_BYTE: merged_o[{lane_i, 3'b000} +: 8] = data_i[7:0];
      SZ_HALF: merged_o[{lane_i[1], 4'b0000} +: 16] = data_i[15:0];
      SZ_WORD: merged_o = data_i;
      default: merged_o = old_i;
    endcase
  end

endmodule

// File: rtl/store_narrow_unit.sv
// Narrowing store unit: word stores write directly, byte/half stores do RMW.
// Optional STORE_RANGE_CHECK_EN flags values that do not fit the store size.
module store_narrow_unit
  import store_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [1:0]        st_size,
  output logic              st_done,
  output logic              st_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  state_e            state_q;
  logic              st_ready_q;
  logic              st_done_q;
  logic              st_err_q;
  logic              mem_rd_q;
  logic              mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        size_q;
  logic [1:0]        lane_q;
  logic              rng_err_q;

  logic              req_bad;
  logic              range_bad;
  logic [DATA_W-1:0] merged;

  always_comb begin
    req_bad = 1'b0;
    case (st_size)
      SZ_HALF:    req_bad = st_addr[0];
      SZ_WORD:    req_bad = |st_addr[1:0];
      SZ_ILLEGAL: req_bad = 1'b1;
      default:    req_bad = 1'b0;
    endcase
  end

`ifdef STORE_RANGE_CHECK_EN
  assign range_bad = ~fits_signed(st_data, st_size);
`else
  assign range_bad = 1'b0;
`endif

  store_merge u_merge (
    .old_i    (mem_rdata),
    .data_i   (data_q),
    .size_i   (size_q),
    .lane_i   (lane_q),
    .merged_o (merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      st_ready_q  <= 1'b1;
      st_done_q   <= 1'b0;
      st_err_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      data_q      <= '0;
      size_q      <= SZ_BYTE;
      lane_q      <= 2'b00;
      rng_err_q   <= 1'b0;
    end else begin
      st_done_q <= 1'b0;
      st_err_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (st_valid) begin
            if (req_bad) begin
              st_done_q <= 1'b1;
              st_err_q  <= 1'b1;
            end else begin
              mem_addr_q <= {st_addr[ADDR_W-1:2], 2'b00};
              data_q     <= st_data;
              size_q     <= st_size;
              lane_q     <= st_addr[1:0];
              rng_err_q  <= range_bad;
              st_ready_q <= 1'b0;
              if (st_size == SZ_WORD) begin
                mem_wr_q    <= 1'b1;
                mem_wdata_q <= st_data;
                state_q     <= S_WRITE;
              end else begin
                mem_rd_q <= 1'b1;
                state_q  <= S_READ;
              end
            end
          end
        end
        S_READ: begin
          if (mem_ack) begin
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b1;
            mem_wdata_q <= merged;
            state_q     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            mem_wr_q   <= 1'b0;
            st_done_q  <= 1'b1;
            st_err_q   <= rng_err_q;
            st_ready_q <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          st_ready_q <= 1'b1;
          mem_rd_q   <= 1'b0;
          mem_wr_q   <= 1'b0;
        end
      endcase
    end
  end

  assign st_ready  = st_ready_q;
  assign st_done   = st_done_q;
  assign st_err    = st_err_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Directed bench for store_narrow_unit and its lane-merge sub-module.
// Range-check expectations follow STORE_RANGE_CHECK_EN.
module tb_store_narrow_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_done;
  logic        st_err;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic [31:0] m_old, m_data, m_out;
  logic [1:0]  m_size, m_lane;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  store_narrow_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_size   (st_size),
    .st_done   (st_done),
    .st_err    (st_err),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  store_merge u_merge (
    .old_i    (m_old),
    .data_i   (m_data),
    .size_i   (m_size),
    .lane_i   (m_lane),
    .merged_o (m_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] s);
    st_addr  = a;
    st_data  = d;
    st_size  = s;
    st_valid = 1'b1;
    tick();
    st_valid = 1'b0;
  endtask

  // Zero-wait byte store from the current cycle; ends in the done cycle.
  task automatic byte_rmw(input string tag, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] rd,
                          input logic [31:0] exp_w, input logic exp_e);
    req(a, d, 2'b00);
    chk({tag, "_rd"}, mem_rd, 1);
    mem_ack   = 1'b1;
    mem_rdata = rd;
    tick();
    chk({tag, "_wr"}, mem_wr, 1);
    chk({tag, "_wd"}, mem_wdata, exp_w);
    tick();
    mem_ack = 1'b0;
    chk({tag, "_done"}, st_done, 1);
    chk({tag, "_err"}, st_err, exp_e);
  endtask

  logic [31:0] mg_old [8];
  logic [1:0]  mg_sz  [8];
  logic [1:0]  mg_ln  [8];
  logic [31:0] mg_exp [8];
  logic [31:0] e_addr [3];
  logic [1:0]  e_size [3];
  logic        rng_e;

  initial begin
    mg_sz  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
    mg_ln  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd0, 2'd1};
    mg_exp = '{32'h112233DD, 32'h1122DD44, 32'h11DD3344, 32'hDD223344,
               32'h1122CCDD, 32'hCCDD3344, 32'hAABBCCDD, 32'h11223344};
    e_addr = '{32'h401, 32'h408, 32'h102};
    e_size = '{2'b01, 2'b11, 2'b10};
`ifdef STORE_RANGE_CHECK_EN
    rng_e = 1'b1;
`else
    rng_e = 1'b0;
`endif

    reset     = 1'b1;
    st_valid  = 1'b0;
    st_addr   = '0;
    st_data   = '0;
    st_size   = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    m_old     = 32'h11223344;
    m_data    = 32'hAABBCCDD;

    for (int i = 0; i < 8; i++) begin
      m_size = mg_sz[i];
      m_lane = mg_ln[i];
      #1;
      chk($sformatf("merge%0d", i), m_out, mg_exp[i]);
    end

    #20;
    chk("rst_ready", st_ready, 1);
    chk("rst_done", st_done, 0);
    chk("rst_err", st_err, 0);
    chk("rst_rd", mem_rd, 0);
    chk("rst_wr", mem_wr, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // aligned word store, zero wait, then a back-to-back word store
    req(32'h100, 32'hDEADBEEF, 2'b10);
    chk("w_wr", mem_wr, 1);
    chk("w_rd", mem_rd, 0);
    chk("w_addr", mem_addr, 32'h100);
    chk("w_wd", mem_wdata, 32'hDEADBEEF);
    chk("w_ready", st_ready, 0);
    chk("w_done0", st_done, 0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("w_done", st_done, 1);
    chk("w_err", st_err, 0);
    chk("w_wr0", mem_wr, 0);
    chk("w_rdy1", st_ready, 1);
    req(32'h104, 32'h12345678, 2'b10);
    chk("b2b_wr", mem_wr, 1);
    chk("b2b_addr", mem_addr, 32'h104);
    chk("b2b_wd", mem_wdata, 32'h12345678);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("b2b_done", st_done, 1);
    tick();
    chk("done_pulse", st_done, 0);

    // byte store with RMW
    req(32'h203, 32'h000000AB, 2'b00);
    chk("b_rd", mem_rd, 1);
    chk("b_wr0", mem_wr, 0);
    chk("b_addr", mem_addr, 32'h200);
    mem_ack   = 1'b1;
    mem_rdata = 32'h11223344;
    tick();
    chk("b_rd0", mem_rd, 0);
    chk("b_wr", mem_wr, 1);
    chk("b_wd", mem_wdata, 32'hAB223344);
    chk("b_done0", st_done, 0);
    tick();
    mem_ack = 1'b0;
    chk("b_done", st_done, 1);
    chk("b_err", st_err, 0);
    tick();

    // half store, two wait cycles per access
    req(32'h302, 32'h0000CAFE, 2'b01);
    for (int i = 0; i < 3; i++) begin
      chk("h_rd", mem_rd, 1);
      chk("h_wr0", mem_wr, 0);
      chk("h_addr", mem_addr, 32'h300);
      chk("h_done0", st_done, 0);
      if (i == 2) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'h55667788;
      end
      tick();
    end
    mem_ack   = 1'b0;
    mem_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      chk("h_wr", mem_wr, 1);
      chk("h_rd0", mem_rd, 0);
      chk("h_addr2", mem_addr, 32'h300);
      chk("h_wd", mem_wdata, 32'hCAFE7788);
      chk("h_done1", st_done, 0);
      if (i == 2) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    chk("h_done", st_done, 1);
    chk("h_err", st_err, 0);
    tick();

    // error requests: misaligned half, illegal size, misaligned word
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'b1;
      req(e_addr[i], 32'h1, e_size[i]);
      mem_ack = 1'b0;
      chk($sformatf("e%0d_done", i), st_done, 1);
      chk($sformatf("e%0d_err", i), st_err, 1);
      chk($sformatf("e%0d_rd", i), mem_rd, 0);
      chk($sformatf("e%0d_wr", i), mem_wr, 0);
      chk($sformatf("e%0d_rdy", i), st_ready, 1);
      tick();
      chk($sformatf("e%0d_rd1", i), mem_rd, 0);
      chk($sformatf("e%0d_wr1", i), mem_wr, 0);
    end

    // reset while reading
    req(32'h501, 32'h77, 2'b00);
    chk("r_rd", mem_rd, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("r_rd_drop", mem_rd, 0);
    chk("r_rdy", st_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r_nodone", st_done, 0);
      chk("r_idle_rd", mem_rd, 0);
      chk("r_idle_rdy", st_ready, 1);
    end
    req(32'h600, 32'h0BADF00D, 2'b10);
    chk("r_w_wr", mem_wr, 1);
    chk("r_w_wd", mem_wdata, 32'h0BADF00D);
    chk("r_w_addr", mem_addr, 32'h600);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("r_w_done", st_done, 1);
    chk("r_w_err", st_err, 0);
    tick();

    // range check: 0x80 does not fit a signed byte, 0xFFFFFF80 does
    byte_rmw("rc1", 32'h700, 32'h00000080, 32'h0, 32'h00000080, rng_e);
    tick();
    byte_rmw("rc2", 32'h701, 32'hFFFFFF80, 32'hA5A5A5A5, 32'hA5A580A5, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
